soc_reset_sequencer: RTL and testbench
======================================

# soc_reset_sequencer

Reset sequencer for the FPGA SoC top. It qualifies the board reset button and the MMCM lock indication, then releases the SoC resets in a fixed order: interconnect, then peripherals, then the E203 core/AON external reset. It replaces the ad-hoc arrangement in which `ck_rst` drove the MMCM, the processor-system reset and `io_pads_aon_erst_n_i_ival` all at once. It runs on the 16 MHz SoC clock and sits between the clock IP and `e203_soc_top`.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive synchronized-high cycles of `ext_rst_n` needed to leave HOLD. Must be ≥1.
- `LOCK_FILTER`, default 4: consecutive synchronized-high cycles of `mmcm_locked` needed to leave LOCK. Must be ≥1.
- `PERIPH_DELAY`, default 8: cycles from interconnect release to peripheral release. Must be ≥1.
- `CORE_DELAY`, default 8: cycles from peripheral release to core release. Must be ≥1.

Ports:
- `clk` input, 1 bit: 16 MHz SoC clock.
- `reset` input, 1 bit: **synchronous, active-high** reset.
- `ext_rst_n` input, 1 bit: board reset button, active-low, asynchronous to `clk`.
- `mmcm_locked` input, 1 bit: MMCM lock, asynchronous to `clk`.
- `sw_rst_req` input, 1 bit: synchronous single-cycle software/debug reset request.
- `interconnect_aresetn` output, 1 bit: interconnect reset, active-low.
- `periph_reset` output, 1 bit: peripheral reset, active-high.
- `core_rst_n` output, 1 bit: drives `io_pads_aon_erst_n_i_ival`, active-low.
- `done` output, 1 bit: high only in RUN.
- `seq_state` output, 3 bits: current state encoding.

## Operation
- Synchronizers:
  - `ext_rst_n` and `mmcm_locked` each pass through a 2-flop synchronizer.
  - Both synchronizer flops reset to 0.
  - The FSM uses only the second-stage outputs, called `ext_s` and `lock_s` below.
- States and encodings: HOLD=0, LOCK=1, ICN=2, PERIPH=3, RUN=4. Codes 5–7 are illegal and go to HOLD on the next edge.
- HOLD:
  - A debounce counter increments while `ext_s`=1 and clears while `ext_s`=0.
  - When `ext_s`=1 and the counter equals `DEBOUNCE_CYCLES`−1, go to LOCK.
- LOCK:
  - A lock counter increments while `lock_s`=1.
  - When `lock_s`=1 and the counter equals `LOCK_FILTER`−1, go to ICN.
- ICN: the delay counter counts from 0. At `PERIPH_DELAY`−1, go to PERIPH.
- PERIPH: the delay counter counts from 0. At `CORE_DELAY`−1, go to RUN.
- RUN: hold until a fault occurs.
- Fault condition (`ext_s`=0 or `lock_s`=0), evaluated in every state other than HOLD:
  - Go to HOLD on the next edge.
  - Fault has priority over any forward transition in the same cycle.
  - In LOCK, `lock_s`=0 is a fault, so LOCK itself returns to HOLD.
- `sw_rst_req`=1 in RUN goes to HOLD. It is ignored in all other states.
- Every counter clears on entry to any state.
- Counter widths are $clog2(param)+1. Counters never wrap, because the transition fires at the terminal count.
- Outputs are registered and updated on the same edge the state register loads, with no combinational decode to the pins:

| State | `interconnect_aresetn` | `periph_reset` | `core_rst_n` | `done` |
|---|---|---|---|---|
| HOLD, LOCK | 0 | 1 | 0 | 0 |
| ICN | 1 | 1 | 0 | 0 |
| PERIPH | 1 | 0 | 0 | 0 |
| RUN | 1 | 0 | 1 | 1 |

## Timing
- During reset and on the first edge after it (all outputs registered):
  - `seq_state`=0
  - `interconnect_aresetn`=0
  - `periph_reset`=1
  - `core_rst_n`=0
  - `done`=0
  - all counters and synchronizer flops are 0.
- Edge numbering: edge 1 is the first rising edge with `reset`=0.
- Release sequence with `ext_rst_n`=`mmcm_locked`=1 throughout and default parameters:

| Edge | Enters | Visible change |
|---|---|---|
| 2 | — | `ext_s` = `lock_s` = 1 |
| 18 | LOCK | — |
| 22 | ICN | `interconnect_aresetn` rises |
| 30 | PERIPH | `periph_reset` falls |
| 38 | RUN | `core_rst_n` and `done` rise |

- General formulas for the same conditions:
  - LOCK entry at edge 2+`DEBOUNCE_CYCLES`.
  - ICN entry at edge 2+`DEBOUNCE_CYCLES`+`LOCK_FILTER`.
  - Each subsequent stage follows after its delay parameter in cycles.
- Fault latency: an async input falling between edges k−1 and k asserts all resets on edge k+2. That is 3 edges, with no intermediate partial-release state.
- `sw_rst_req` sampled high on edge k in RUN asserts all resets on edge k.
- A glitch on `ext_rst_n` shorter than one clock may be missed by the synchronizer. A glitch that is seen restarts the debounce from 0.
- Synchronous `reset` asserted mid-sequence returns the block to reset values on that edge, regardless of state.

## Test plan
- **Nominal release.** Defaults, both inputs high from reset release -> `interconnect_aresetn`↑ at edge 22, `periph_reset`↓ at edge 30, `core_rst_n`↑ and `done`↑ at edge 38, `seq_state` sequence 0,1,2,3,4.
- **Bouncing button.** `ext_rst_n` high for 10 cycles, low for 1, then high -> debounce restarts; LOCK entered 16 edges after `ext_s` returns high.
- **Late lock.** `mmcm_locked` rises at edge 50 -> state stays 1 until edge 55 (2 sync + 4 filter − 1), then ICN.
- **Lock loss in RUN.** Drop `mmcm_locked` between edges k−1 and k -> all three resets asserted and `done`=0 on edge k+2; full re-sequence follows after the lock returns.
- **Software reset.** `sw_rst_req` pulse in RUN -> HOLD on the same edge. The same pulse in PERIPH has no effect, and RUN is reached on schedule.
- **Simultaneous events and mid-sequence reset.**
  - `sw_rst_req` and lock loss together -> single HOLD entry.
  - `reset` asserted while in PERIPH -> reset values on that edge.
  - Force an illegal state 6 -> HOLD next edge.

Source files
------------

// File: rtl/soc_reset_sequencer.sv
// Reset sequencer: qualifies the board reset button and MMCM lock, then releases
// interconnect, peripheral and core resets in order, re-asserting all of them on any fault.
module soc_reset_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCK_FILTER     = 4,
    parameter int PERIPH_DELAY    = 8,
    parameter int CORE_DELAY      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ext_rst_n,
    input  logic       mmcm_locked,
    input  logic       sw_rst_req,
    output logic       interconnect_aresetn,
    output logic       periph_reset,
    output logic       core_rst_n,
    output logic       done,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        LOCK   = 3'd1,
        ICN    = 3'd2,
        PERIPH = 3'd3,
        RUN    = 3'd4
    } state_t;

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LOCK_W = $clog2(LOCK_FILTER) + 1;
    localparam int DLY_MAX = (PERIPH_DELAY > CORE_DELAY) ? PERIPH_DELAY : CORE_DELAY;
    localparam int DLY_W  = $clog2(DLY_MAX) + 1;

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [DLY_W-1:0]  PERIPH_LAST = DLY_W'(PERIPH_DELAY - 1);
    localparam logic [DLY_W-1:0]  CORE_LAST   = DLY_W'(CORE_DELAY - 1);

    logic              r_extMeta;
    logic              r_extS;
    logic              r_lockMeta;
    logic              r_lockS;
    logic [2:0]        r_state;
    logic [DEB_W-1:0]  r_debCnt;
    logic [LOCK_W-1:0] r_lockCnt;
    logic [DLY_W-1:0]  r_dlyCnt;
    state_t            w_nextState;
    logic              w_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_extMeta  <= 1'b0;
            r_extS     <= 1'b0;
            r_lockMeta <= 1'b0;
            r_lockS    <= 1'b0;
        end else begin
            r_extMeta  <= ext_rst_n;
            r_extS     <= r_extMeta;
            r_lockMeta <= mmcm_locked;
            r_lockS    <= r_lockMeta;
        end
    end

    // A fault outranks every forward transition; codes 5-7 fall into the default and recover to HOLD.
    always_comb begin
        w_nextState = HOLD;
        w_fault     = !r_extS || !r_lockS;
        case (r_state)
            HOLD: begin
                if (r_extS && (r_debCnt == DEB_LAST)) w_nextState = LOCK;
                else                                  w_nextState = HOLD;
            end
            LOCK: begin
                if (w_fault)                         w_nextState = HOLD;
                else if (r_lockCnt == LOCK_LAST)     w_nextState = ICN;
                else                                 w_nextState = LOCK;
            end
            ICN: begin
                if (w_fault)                         w_nextState = HOLD;
                else if (r_dlyCnt == PERIPH_LAST)    w_nextState = PERIPH;
                else                                 w_nextState = ICN;
            end
            PERIPH: begin
                if (w_fault)                         w_nextState = HOLD;
                else if (r_dlyCnt == CORE_LAST)      w_nextState = RUN;
                else                                 w_nextState = PERIPH;
            end
            RUN: begin
                if (w_fault || sw_rst_req)           w_nextState = HOLD;
                else                                 w_nextState = RUN;
            end
            default: w_nextState = HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Counters clear whenever the state changes, so each stage starts counting from zero.
    always_ff @(posedge clk) begin
        if (reset || (w_nextState != r_state)) begin
            r_debCnt  <= '0;
            r_lockCnt <= '0;
            r_dlyCnt  <= '0;
        end else begin
            case (r_state)
                HOLD: begin
                    if (r_extS) r_debCnt <= r_debCnt + DEB_W'(1);
                    else        r_debCnt <= '0;
                end
                LOCK: begin
                    if (r_lockS) r_lockCnt <= r_lockCnt + LOCK_W'(1);
                end
                ICN, PERIPH: begin
                    r_dlyCnt <= r_dlyCnt + DLY_W'(1);
                end
                default: begin
                    r_dlyCnt <= r_dlyCnt;
                end
            endcase
        end
    end

    // Output pins are decoded from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            interconnect_aresetn <= 1'b0;
            periph_reset         <= 1'b1;
            core_rst_n           <= 1'b0;
            done                 <= 1'b0;
        end else begin
            case (w_nextState)
                ICN: begin
                    interconnect_aresetn <= 1'b1;
                    periph_reset         <= 1'b1;
                    core_rst_n           <= 1'b0;
                    done                 <= 1'b0;
                end
                PERIPH: begin
                    interconnect_aresetn <= 1'b1;
                    periph_reset         <= 1'b0;
                    core_rst_n           <= 1'b0;
                    done                 <= 1'b0;
                end
                RUN: begin
                    interconnect_aresetn <= 1'b1;
                    periph_reset         <= 1'b0;
                    core_rst_n           <= 1'b1;
                    done                 <= 1'b1;
                end
                default: begin
                    interconnect_aresetn <= 1'b0;
                    periph_reset         <= 1'b1;
                    core_rst_n           <= 1'b0;
                    done                 <= 1'b0;
                end
            endcase
        end
    end

    assign seq_state = r_state;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Scoreboard bench for soc_reset_sequencer: expected state/output snapshots are queued
// per edge from the release schedule and compared when the run reaches that edge.
module tb_soc_reset_sequencer;

    localparam logic [2:0] S_HOLD   = 3'd0;
    localparam logic [2:0] S_LOCK   = 3'd1;
    localparam logic [2:0] S_ICN    = 3'd2;
    localparam logic [2:0] S_PERIPH = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;

    typedef struct {
        int         edgeNo;
        logic [6:0] exp;
        string      name;
    } sbEntry_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       extRstN = 1'b0;
    logic       mmcmLocked = 1'b0;
    logic       swRstReq = 1'b0;
    logic       icnAresetn;
    logic       periphReset;
    logic       coreRstN;
    logic       doneOut;
    logic [2:0] seqState;

    int       total = 0;
    int       bad = 0;
    int       edgeNo = 0;
    sbEntry_t sbq[$];

    wire [6:0] w_obs = {seqState, icnAresetn, periphReset, coreRstN, doneOut};

    soc_reset_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .ext_rst_n           (extRstN),
        .mmcm_locked         (mmcmLocked),
        .sw_rst_req          (swRstReq),
        .interconnect_aresetn(icnAresetn),
        .periph_reset        (periphReset),
        .core_rst_n          (coreRstN),
        .done                (doneOut),
        .seq_state           (seqState)
    );

    always #5 clk = ~clk;

    // Expected {state, aresetn, periph_reset, core_rst_n, done} for a given state.
    function automatic logic [6:0] expOf(input logic [2:0] s);
        case (s)
            S_ICN:    return {s, 4'b1100};
            S_PERIPH: return {s, 4'b1000};
            S_RUN:    return {s, 4'b1011};
            default:  return {s, 4'b0100};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edgeNo++;
    endtask

    task automatic expectAt(input int e, input logic [2:0] s, input string name);
        sbq.push_back('{e, expOf(s), name});
    endtask

    task automatic applyReset(input logic ext, input logic lock);
        reset = 1'b1;
        extRstN = ext;
        mmcmLocked = lock;
        swRstReq = 1'b0;
        sbq.delete();
        repeat (3) tick();
        reset = 1'b0;
        edgeNo = 0;
    endtask

    task automatic test_reset();
        sbEntry_t ent;
        reset = 1'b1;
        extRstN = 1'b1;
        mmcmLocked = 1'b1;
        swRstReq = 1'b0;
        sbq.delete();
        repeat (2) tick();
        total++;
        if (w_obs !== 7'b000_0100) begin
            bad++;
            $display("[TB] FAIL reset/during: observed %b expected %b", w_obs, 7'b000_0100);
        end
        reset = 1'b0;
        edgeNo = 0;
        expectAt(1, S_HOLD, "edge1");
        expectAt(2, S_HOLD, "edge2");
        for (int i = 0; i < 3; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL reset/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL reset/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    task automatic test_nominal();
        sbEntry_t ent;
        applyReset(1'b1, 1'b1);
        expectAt(1, S_HOLD, "hold_start");
        expectAt(17, S_HOLD, "hold_end");
        expectAt(18, S_LOCK, "lock_entry");
        expectAt(21, S_LOCK, "lock_end");
        expectAt(22, S_ICN, "icn_entry");
        expectAt(29, S_ICN, "icn_end");
        expectAt(30, S_PERIPH, "periph_entry");
        expectAt(37, S_PERIPH, "periph_end");
        expectAt(38, S_RUN, "run_entry");
        expectAt(45, S_RUN, "run_hold");
        for (int i = 0; i < 46; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL nominal/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL nominal/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    task automatic test_bounce();
        sbEntry_t ent;
        applyReset(1'b0, 1'b1);
        extRstN = 1'b1;
        expectAt(12, S_HOLD, "before_glitch");
        expectAt(28, S_HOLD, "restarted_hold");
        expectAt(29, S_LOCK, "lock_entry");
        expectAt(32, S_LOCK, "lock_end");
        expectAt(33, S_ICN, "icn_entry");
        for (int i = 0; i < 35; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL bounce/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
            if (edgeNo == 10) extRstN = 1'b0;
            if (edgeNo == 11) extRstN = 1'b1;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL bounce/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    task automatic test_late_lock();
        sbEntry_t ent;
        applyReset(1'b1, 1'b0);
        expectAt(17, S_HOLD, "hold");
        expectAt(18, S_LOCK, "lock_try1");
        expectAt(19, S_HOLD, "lock_fault1");
        expectAt(35, S_LOCK, "lock_try2");
        expectAt(36, S_HOLD, "lock_fault2");
        expectAt(51, S_HOLD, "hold3");
        expectAt(52, S_LOCK, "lock_try3");
        expectAt(55, S_LOCK, "lock_filter_end");
        expectAt(56, S_ICN, "icn_entry");
        for (int i = 0; i < 58; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL late_lock/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
            if (edgeNo == 49) mmcmLocked = 1'b1;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL late_lock/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    task automatic test_lock_loss();
        sbEntry_t ent;
        applyReset(1'b1, 1'b1);
        expectAt(38, S_RUN, "run_entry");
        expectAt(46, S_RUN, "edge_k");
        expectAt(47, S_RUN, "edge_k1");
        expectAt(48, S_HOLD, "edge_k2_hold");
        expectAt(63, S_HOLD, "rehold");
        expectAt(64, S_LOCK, "relock");
        expectAt(68, S_ICN, "reicn");
        expectAt(76, S_PERIPH, "reperiph");
        expectAt(84, S_RUN, "rerun");
        for (int i = 0; i < 86; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL lock_loss/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
            if (edgeNo == 45) mmcmLocked = 1'b0;
            if (edgeNo == 50) mmcmLocked = 1'b1;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL lock_loss/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    task automatic test_sw_reset();
        sbEntry_t ent;
        applyReset(1'b1, 1'b1);
        expectAt(30, S_PERIPH, "periph_entry");
        expectAt(33, S_PERIPH, "ignored_in_periph");
        expectAt(37, S_PERIPH, "periph_end");
        expectAt(38, S_RUN, "run_on_schedule");
        expectAt(40, S_RUN, "run_before_req");
        expectAt(41, S_HOLD, "hold_same_edge");
        expectAt(56, S_HOLD, "rehold");
        expectAt(57, S_LOCK, "relock");
        for (int i = 0; i < 58; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL sw_reset/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
            if (edgeNo == 32) swRstReq = 1'b1;
            if (edgeNo == 33) swRstReq = 1'b0;
            if (edgeNo == 40) swRstReq = 1'b1;
            if (edgeNo == 41) swRstReq = 1'b0;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL sw_reset/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    task automatic test_simultaneous();
        sbEntry_t ent;
        applyReset(1'b1, 1'b1);
        expectAt(38, S_RUN, "run_entry");
        expectAt(42, S_RUN, "run_before");
        expectAt(43, S_HOLD, "joint_hold");
        expectAt(44, S_HOLD, "stay_hold");
        expectAt(50, S_HOLD, "still_hold");
        for (int i = 0; i < 51; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL simultaneous/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
            if (edgeNo == 40) mmcmLocked = 1'b0;
            if (edgeNo == 42) swRstReq = 1'b1;
            if (edgeNo == 43) swRstReq = 1'b0;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL simultaneous/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
        mmcmLocked = 1'b1;
    endtask

    task automatic test_mid_reset();
        sbEntry_t ent;
        applyReset(1'b1, 1'b1);
        expectAt(30, S_PERIPH, "periph_entry");
        expectAt(32, S_PERIPH, "periph_before");
        expectAt(33, S_HOLD, "reset_edge");
        expectAt(34, S_HOLD, "after_release_edge1");
        expectAt(50, S_HOLD, "after_release_edge17");
        expectAt(51, S_LOCK, "after_release_lock");
        expectAt(55, S_ICN, "after_release_icn");
        for (int i = 0; i < 56; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL mid_reset/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
            if (edgeNo == 32) reset = 1'b1;
            if (edgeNo == 33) reset = 1'b0;
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL mid_reset/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    task automatic test_illegal_state();
        sbEntry_t ent;
        applyReset(1'b1, 1'b1);
        expectAt(38, S_RUN, "run_entry");
        expectAt(40, S_RUN, "run_before_force");
        expectAt(41, S_HOLD, "illegal_to_hold");
        expectAt(42, S_HOLD, "stay_hold");
        for (int i = 0; i < 43; i++) begin
            tick();
            while (sbq.size() != 0 && sbq[0].edgeNo == edgeNo) begin
                ent = sbq.pop_front();
                total++;
                if (w_obs !== ent.exp) begin
                    bad++;
                    $display("[TB] FAIL illegal/%s edge %0d: observed %b expected %b", ent.name, edgeNo, w_obs, ent.exp);
                end
            end
            if (edgeNo == 40) begin
                @(negedge clk);
                force dut.r_state = 3'd6;
                #1;
                release dut.r_state;
                total++;
                if (seqState !== 3'd6) begin
                    bad++;
                    $display("[TB] FAIL illegal/forced_code: observed %0d expected 6", seqState);
                end
            end
        end
        if (sbq.size() != 0) begin
            total++; bad++;
            $display("[TB] FAIL illegal/unreached: %0d expectations left, observed %b", sbq.size(), w_obs);
            sbq.delete();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bounce();
        test_late_lock();
        test_lock_loss();
        test_sw_reset();
        test_simultaneous();
        test_mid_reset();
        test_illegal_state();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
